amba3_apb_slave_mem: RTL and testbench
======================================

// Module: amba3_apb_slave_mem
// PURPOSE
//  Synthesizable AMBA3 APB slave backed by a word-addressed register memory.
//  Adds programmable wait states and PSLVERR error signalling.
//  Serves as a DUT-side target for the APB master VIP and as a scratch memory in subsystem benches.
// PARAMETERS
//  ADDR_SIZE  32  paddr width
//  DATA_SIZE  32  pwdata/prdata width; must be 8, 16, 32 or 64
//  DEPTH      256 number of DATA_SIZE-bit words
//  BASE_ADDR  0   byte address of word 0
//  WAIT_W     4   width of wait_cfg; max wait states = 2**WAIT_W-1
// PORTS
//  pclk      in   1          APB clock, all state on rising edge
//  preset    in   1          async, active-high reset
//  paddr     in   ADDR_SIZE  byte address
//  psel      in   1          slave select
//  penable   in   1          access phase
//  pwrite    in   1          1=write, 0=read
//  pwdata    in   DATA_SIZE  write data
//  pready    out  1          transfer complete
//  prdata    out  DATA_SIZE  read data, valid only while pready=1
//  pslverr   out  1          error response, valid only while pready=1
//  wait_cfg  in   WAIT_W     wait states inserted per transfer
//  prot_err  out  1          one-cycle pulse on an APB protocol violation
// BEHAVIOUR
//  Reset: pready=0, prdata=0, pslverr=0, prot_err=0, state=IDLE, wait counter=0.
//   Reset is asynchronous; memory contents are not reset.
//  FSM states: IDLE, ACCESS.
//   IDLE -> ACCESS when psel=1 and penable=0 (setup phase). At that edge:
//    latch paddr/pwrite/pwdata; cnt <= wait_cfg; pready <= (wait_cfg==0).
//   ACCESS, pready=0: cnt <= cnt-1; pready <= (cnt==1).
//   ACCESS, pready=1, psel=1, penable=1: transfer completes at this edge.
//    Write commits to memory here; pready <= 0; return to IDLE.
//  Latency: transfer = 2+wait_cfg cycles (setup, wait_cfg waits, one ready cycle).
//  Back-to-back: a setup phase in the cycle after completion is accepted. No idle cycle is needed.
//  prdata/pslverr are registered and loaded in the same edge that raises pready.
//   Both are held 0 whenever pready=0.
//  Decode: off = paddr - BASE_ADDR; idx = off >> log2(DATA_SIZE/8).
//   Error if paddr < BASE_ADDR, idx >= DEPTH, or off is not word-aligned.
//   On error: pslverr=1 with pready; write suppressed; prdata=0.
//  wait_cfg is sampled only at the setup edge; mid-transfer changes are ignored.
//  Abort: psel=0 while in ACCESS -> IDLE next edge; no write; pready/pslverr -> 0.
//  Protocol errors (prot_err pulses 1 cycle, state unchanged):
//   psel=1 and penable=1 while in IDLE;
//   paddr, pwrite or pwdata changed during ACCESS (compared against latched values).
//   Latched values are used for the transfer.
//  Memory read for a read transfer uses the latched idx. Read-after-write to the same word returns the new data.
// STRUCTURE
//  pkg_amba3: typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e;
//   function apb_word_index(addr, base, data_size) returning idx and a misaligned flag.
//  Sub-module amba3_apb_mem_array: DEPTH x DATA_SIZE, 1 sync write port, 1 async read port, no reset.
//  Top holds the FSM, wait counter, decode, latches and protocol checker.
// TESTING
//  1. wait_cfg=0: write 0x100<-0xDEADBEEF, then read 0x100.
//     -> pready in 2nd cycle of each transfer; prdata=0xDEADBEEF; pslverr=0.
//  2. wait_cfg=3: read 0x0 -> pready high exactly in cycle 5 after setup; prdata=0 after a prior write of 0.
//  3. Write to BASE_ADDR+4*DEPTH and to 0x102 -> pslverr=1 with pready; a read of word 0x100 is unchanged.
//  4. Back-to-back: write 0x8<-0x1 immediately followed by read 0x8 -> prdata=0x1, no idle cycle.
//  5. Abort: wait_cfg=5, deassert psel after 2 access cycles on a write of 0xA5 to 0x10.
//     -> memory word 0x10 unchanged; the next transfer completes normally.
//  6. preset=1 during a wait state, then penable=1 in IDLE.
//     -> outputs 0 asynchronously; prot_err pulses once.

Source files
------------

// File: rtl/amba3_apb_slave_mem_pkg.sv
// Shared types and address-decode helper for the AMBA3 APB slave memory.
package pkg_amba3;

    typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e;

    typedef struct packed {
        logic [63:0] idx;
        logic        misaligned;
    } apb_word_idx_t;

    function automatic apb_word_idx_t apb_word_index(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned data_size
    );
        apb_word_idx_t res;
        logic [63:0]   off;
        int unsigned   sh;
        case (data_size)
            8:       sh = 0;
            16:      sh = 1;
            64:      sh = 3;
            default: sh = 2;
        endcase
        off            = addr - base;
        res.idx        = off >> sh;
        res.misaligned = (off & ((64'd1 << sh) - 64'd1)) != 64'd0;
        return res;
    endfunction

endpackage

// File: rtl/amba3_apb_mem_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port, no reset.
module amba3_apb_mem_array #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned AW        = 8
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/amba3_apb_slave_mem.sv
// AMBA3 APB slave over a register memory with programmable wait states,
// PSLVERR on bad decode and a protocol-violation pulse.
module amba3_apb_slave_mem
    import pkg_amba3::*;
#(
    parameter int unsigned     ADDR_SIZE = 32,
    parameter int unsigned     DATA_SIZE = 32,
    parameter int unsigned     DEPTH     = 256,
    parameter longint unsigned BASE_ADDR = 0,
    parameter int unsigned     WAIT_W    = 4
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic                 pready,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pslverr,
    input  logic [WAIT_W-1:0]    wait_cfg,
    output logic                 prot_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_slv_state_e       r_state, w_state_nx;
    logic [WAIT_W-1:0]    r_cnt, w_cnt_nx;
    logic                 r_pready, w_pready_nx;
    logic [DATA_SIZE-1:0] r_prdata, w_prdata_nx;
    logic                 r_pslverr, w_pslverr_nx;
    logic                 r_prot_err, w_prot_err;
    logic [ADDR_SIZE-1:0] r_paddr;
    logic                 r_pwrite;
    logic [DATA_SIZE-1:0] r_pwdata;

    logic [ADDR_SIZE-1:0] w_dec_addr;
    logic                 w_dec_write;
    apb_word_idx_t        w_dec;
    logic                 w_err;
    logic [AW-1:0]        w_idx;
    logic [DATA_SIZE-1:0] w_rdata;
    logic [DATA_SIZE-1:0] w_load_data;
    logic                 w_we;
    logic                 w_setup;

    assign w_setup = (r_state == APB_IDLE) && psel && !penable;

    // With zero wait states pready rises on the setup edge itself, before the
    // latches hold the address, so decode follows the live bus while idle.
    assign w_dec_addr  = (r_state == APB_IDLE) ? paddr  : r_paddr;
    assign w_dec_write = (r_state == APB_IDLE) ? pwrite : r_pwrite;
    assign w_dec       = apb_word_index(64'(w_dec_addr), BASE_ADDR, DATA_SIZE);
    assign w_err       = (64'(w_dec_addr) < BASE_ADDR) || w_dec.misaligned ||
                         (w_dec.idx >= 64'(DEPTH));
    assign w_idx       = w_dec.idx[AW-1:0];
    assign w_load_data = (w_dec_write || w_err) ? '0 : w_rdata;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_pready_nx  = r_pready;
        w_prdata_nx  = r_prdata;
        w_pslverr_nx = r_pslverr;
        w_prot_err   = 1'b0;
        w_we         = 1'b0;
        if (r_state == APB_IDLE) begin
            if (psel && penable) begin
                w_prot_err = 1'b1;
            end else if (psel) begin
                w_state_nx  = APB_ACCESS;
                w_cnt_nx    = wait_cfg;
                w_pready_nx = (wait_cfg == '0);
                if (wait_cfg == '0) begin
                    w_prdata_nx  = w_load_data;
                    w_pslverr_nx = w_err;
                end
            end
        end else begin
            if (psel && ((paddr != r_paddr) || (pwrite != r_pwrite) || (pwdata != r_pwdata)))
                w_prot_err = 1'b1;
            if (!psel) begin
                w_state_nx   = APB_IDLE;
                w_cnt_nx     = '0;
                w_pready_nx  = 1'b0;
                w_prdata_nx  = '0;
                w_pslverr_nx = 1'b0;
            end else if (!r_pready) begin
                w_cnt_nx = r_cnt - WAIT_W'(1);
                if (r_cnt == WAIT_W'(1)) begin
                    w_pready_nx  = 1'b1;
                    w_prdata_nx  = w_load_data;
                    w_pslverr_nx = w_err;
                end
            end else if (penable) begin
                w_we         = r_pwrite && !w_err;
                w_state_nx   = APB_IDLE;
                w_pready_nx  = 1'b0;
                w_prdata_nx  = '0;
                w_pslverr_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state    <= APB_IDLE;
            r_cnt      <= '0;
            r_pready   <= 1'b0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
            r_prot_err <= 1'b0;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_pready   <= w_pready_nx;
            r_prdata   <= w_prdata_nx;
            r_pslverr  <= w_pslverr_nx;
            r_prot_err <= w_prot_err;
            if (w_setup) begin
                r_paddr  <= paddr;
                r_pwrite <= pwrite;
                r_pwdata <= pwdata;
            end
        end
    end

    amba3_apb_mem_array #(
        .DEPTH     (DEPTH),
        .DATA_SIZE (DATA_SIZE),
        .AW        (AW)
    ) u_mem (
        .i_clk   (pclk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (r_pwdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    assign pready   = r_pready;
    assign prdata   = r_prdata;
    assign pslverr  = r_pslverr;
    assign prot_err = r_prot_err;

endmodule

// File: tb/tb_amba3_apb_slave_mem.sv
// Directed bench for amba3_apb_slave_mem: latency, decode errors, back-to-back, abort, reset.
module tb_amba3_apb_slave_mem;

    logic        pclk = 1'b0;
    logic        preset;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [3:0]  wait_cfg;
    logic        prot_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_prot  = 0;
    int cyc     = 0;
    int xf_start, xf_end;

    amba3_apb_slave_mem #(
        .ADDR_SIZE (32),
        .DATA_SIZE (32),
        .DEPTH     (256),
        .BASE_ADDR (0),
        .WAIT_W    (4)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .wait_cfg (wait_cfg),
        .prot_err (prot_err)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;
    always @(negedge pclk) if (prot_err === 1'b1) n_prot++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // wait_cfg is scrambled after setup so the transfer must use the sampled value.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wcfg, output logic [31:0] rdata,
                            output logic err, output int lat);
        int c;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; wait_cfg = wcfg;
        xf_start = cyc;
        @(negedge pclk);
        penable = 1'b1; wait_cfg = wcfg ^ 4'hF; c = 2;
        while (pready !== 1'b1 && c < 40) begin
            @(negedge pclk);
            c++;
        end
        if (pready !== 1'b1) chk("timeout", 64'd0, 64'd1);
        rdata = prdata; err = pslverr; lat = c; xf_end = cyc;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          s;

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; wait_cfg = '0;
        #12;
        chk("rst_pready", pready, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prot_err", prot_err, 0);
        @(negedge pclk) preset = 1'b0;

        // 1: zero wait states
        apb_xfer(1, 32'h100, 32'hDEADBEEF, 0, rd, er, lat);
        chk("t1_wr_lat", lat, 2);
        chk("t1_wr_err", er, 0);
        apb_xfer(0, 32'h100, 32'h0, 0, rd, er, lat);
        chk("t1_rd_lat", lat, 2);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_err", er, 0);

        // 2: three wait states
        apb_xfer(1, 32'h0, 32'h0, 0, rd, er, lat);
        apb_xfer(0, 32'h0, 32'h0, 3, rd, er, lat);
        chk("t2_rd_lat", lat, 5);
        chk("t2_rd_data", rd, 0);
        chk("t2_rd_err", er, 0);

        // 3: decode errors
        apb_xfer(1, 32'h400, 32'h1234, 0, rd, er, lat);
        chk("t3_oor_err", er, 1);
        apb_xfer(1, 32'h102, 32'h5678, 0, rd, er, lat);
        chk("t3_mis_err", er, 1);
        apb_xfer(0, 32'h400, 32'h0, 0, rd, er, lat);
        chk("t3_oor_rd_err", er, 1);
        chk("t3_oor_rd_data", rd, 0);
        apb_xfer(0, 32'h100, 32'h0, 0, rd, er, lat);
        chk("t3_keep_data", rd, 32'hDEADBEEF);
        chk("t3_keep_err", er, 0);

        // 4: back-to-back write then read
        apb_xfer(1, 32'h8, 32'h1, 0, rd, er, lat);
        s = xf_end;
        apb_xfer(0, 32'h8, 32'h0, 0, rd, er, lat);
        chk("t4_data", rd, 1);
        chk("t4_no_idle", xf_start, s + 1);

        // 5: abort mid-wait
        apb_xfer(1, 32'h10, 32'h55, 0, rd, er, lat);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5; wait_cfg = 4'd5;
        @(negedge pclk) penable = 1'b1;
        @(negedge pclk);
        @(negedge pclk) begin psel = 1'b0; penable = 1'b0; end
        @(negedge pclk);
        chk("t5_abort_pready", pready, 0);
        chk("t5_abort_pslverr", pslverr, 0);
        apb_xfer(0, 32'h10, 32'h0, 5, rd, er, lat);
        chk("t5_data", rd, 32'h55);
        chk("t5_lat", lat, 7);
        chk("t5_no_prot", n_prot, 0);

        // 6: async reset during wait state, then penable in IDLE
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h100; pwdata = 32'h77; wait_cfg = 4'd5;
        @(negedge pclk) penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        #1;
        chk("t6_rst_pready", pready, 0);
        chk("t6_rst_prdata", prdata, 0);
        chk("t6_rst_pslverr", pslverr, 0);
        @(negedge pclk) preset = 1'b0;
        @(negedge pclk);
        chk("t6_prot_pulse", prot_err, 1);
        chk("t6_idle_pready", pready, 0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk("t6_prot_clear", prot_err, 0);
        chk("t6_prot_count", n_prot, 1);
        apb_xfer(0, 32'h100, 32'h0, 0, rd, er, lat);
        chk("t6_no_write", rd, 32'hDEADBEEF);
        @(negedge pclk) begin psel = 1'b0; penable = 1'b0; end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
